// File: rtl/term_pkg.sv
// Shared constants, control codes and state encoding for the text-console writer.
package term_pkg;

  localparam int unsigned COLS   = 70;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;

  localparam logic [7:0] BLANK    = 8'h20;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    INIT_CLEAR,
    IDLE,
    CLEAR_LINE
  } term_state_t;

endpackage

// File: rtl/term_row_ptr.sv
// Modular row counter (0..ROWS-1) with its buffer base address kept alongside,
// so row*COLS never needs a multiplier.
module term_row_ptr
  import term_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [ADDR_W-1:0] base_o
);

  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q  <= '0;
      base_q <= '0;
    end else if (inc_i) begin
      if (row_q == ROW_W'(ROWS - 1)) begin
        row_q  <= '0;
        base_q <= '0;
      end else begin
        row_q  <= row_q + ROW_W'(1);
        base_q <= base_q + ADDR_W'(COLS);
      end
    end
  end

  assign row_o  = row_q;
  assign base_o = base_q;

endmodule

// File: rtl/term_writer.sv
// Text-console writer: ASCII stream in, character-buffer writes out, with cursor,
// control codes and line clearing. TERM_SCROLL_EN selects scrolling instead of wrap.
module term_writer
  import term_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [4:0]        top_row,
  output logic [6:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic              busy
);

  term_state_t       state_q;
  logic              ready_q;
  logic              wr_en_q;
  logic              busy_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [COL_W-1:0]  clr_cnt_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;

  logic              accept_c;
  logic              is_print_c;
  logic              last_col_c;
  logic              last_row_c;
  logic              nl_c;
  logic              clr_c;
  logic              top_inc_c;
  logic [ROW_W-1:0]  phys_row;
  logic [ADDR_W-1:0] cur_base;
  logic [ROW_W-1:0]  top_row_w;
  logic [ADDR_W-1:0] top_base;

  assign accept_c   = char_valid & ready_q;
  assign is_print_c = (char_data >= PRINT_LO) && (char_data <= PRINT_HI);
  assign last_col_c = (col_q == COL_W'(COLS - 1));
  assign last_row_c = (row_q == ROW_W'(ROWS - 1));
  assign nl_c       = accept_c && ((char_data == LF) || (is_print_c && last_col_c));
  assign clr_c      = nl_c && last_row_c;

`ifdef TERM_SCROLL_EN
  assign top_inc_c = clr_c;
`else
  assign top_inc_c = 1'b0;
`endif

  // Cursor physical row advances on every newline; mod-ROWS covers both scroll and wrap.
  term_row_ptr u_cur_ptr (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (nl_c),
    .row_o  (phys_row),
    .base_o (cur_base)
  );

  term_row_ptr u_top_ptr (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (top_inc_c),
    .row_o  (top_row_w),
    .base_o (top_base)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_CLEAR;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b1;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      clr_addr_q <= '0;
      clr_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        INIT_CLEAR: begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= clr_addr_q;
          wr_data_q  <= BLANK;
          clr_addr_q <= clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == ADDR_W'(COLS * ROWS - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (accept_c) begin
            if (is_print_c) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_base + ADDR_W'(col_q);
              wr_data_q <= char_data;
              if (!last_col_c) col_q <= col_q + COL_W'(1);
            end else if (char_data == CR) begin
              col_q <= '0;
            end else if ((char_data == BS) && (col_q != '0)) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_base + ADDR_W'(col_q - COL_W'(1));
              wr_data_q <= BLANK;
              col_q     <= col_q - COL_W'(1);
            end
            if (nl_c) begin
              col_q <= '0;
              if (!last_row_c) row_q <= row_q + ROW_W'(1);
`ifndef TERM_SCROLL_EN
              else row_q <= '0;
`endif
            end
            // Row to blank is the pre-scroll top row (always row 0 when wrapping).
            if (clr_c) begin
              state_q    <= CLEAR_LINE;
              ready_q    <= 1'b0;
              busy_q     <= 1'b1;
              clr_addr_q <= top_base;
              clr_cnt_q  <= '0;
            end
          end
        end
        CLEAR_LINE: begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= clr_addr_q;
          wr_data_q  <= BLANK;
          clr_addr_q <= clr_addr_q + ADDR_W'(1);
          clr_cnt_q  <= clr_cnt_q + COL_W'(1);
          if (clr_cnt_q == COL_W'(COLS - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= INIT_CLEAR;
      endcase
    end
  end

  // Incrementally tracked physical row must equal (top_row + cur_row) mod ROWS.
  always_ff @(posedge clk) begin
    if (!rst) assert (int'(phys_row) == (int'(top_row_w) + int'(row_q)) % int'(ROWS));
  end

  assign char_ready = ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign top_row    = top_row_w;
  assign cur_col    = col_q;
  assign cur_row    = row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: init clear, printing, control codes, line wrap, scroll/wrap.
module tb_term_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [4:0]  top_row;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    logic [6:0]  col;
    logic [4:0]  row;
    int          cyc;
  } wr_t;
  wr_t wq[$];

  term_writer dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .top_row    (top_row),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, cur_col, cur_row, cyc});

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    for (int i = 0; i < 200 && char_ready !== 1'b1; i++) @(negedge clk);
    vec_cnt++;
    if (char_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL send_ready char=%h ready=%b required 1", c, char_ready);
    end
    @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int waited;
    int bad;
    @(negedge clk);
    rst = 1'b1;
    char_valid = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (char_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b1 || wr_addr !== 12'd0 ||
        wr_data !== 8'h00 || top_row !== 5'd0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
      err_cnt++;
      $display("FAIL reset_values rdy=%b we=%b busy=%b addr=%0d data=%h top=%0d col=%0d row=%0d required 0 0 1 0 00 0 0 0",
               char_ready, wr_en, busy, wr_addr, wr_data, top_row, cur_col, cur_row);
    end
    rst = 1'b0;
    wq.delete();
    waited = 0;
    while (char_ready !== 1'b1 && waited < 2300) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    vec_cnt++;
    if (waited != 2100) begin
      err_cnt++;
      $display("FAIL init_duration cycles=%0d required 2100", waited);
    end
    bad = 0;
    foreach (wq[i]) if (wq[i].a !== 12'(i) || wq[i].d !== 8'h20) bad++;
    vec_cnt++;
    if (wq.size() != 2100 || bad != 0) begin
      err_cnt++;
      $display("FAIL init_writes count=%0d bad=%0d required 2100 0", wq.size(), bad);
    end
    vec_cnt++;
    if (cur_col !== 7'd0 || cur_row !== 5'd0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL init_cursor col=%0d row=%0d busy=%b required 0 0 0", cur_col, cur_row, busy);
    end
  endtask

  task automatic test_back_to_back();
    wq.delete();
    send(8'h41);
    send(8'h42);
    settle();
    vec_cnt++;
    if (wq.size() != 2) begin
      err_cnt++;
      $display("FAIL b2b_count writes=%0d required 2", wq.size());
    end else begin
      vec_cnt++;
      if (wq[0].a !== 12'd0 || wq[0].d !== 8'h41 || wq[0].col !== 7'd1 ||
          wq[1].a !== 12'd1 || wq[1].d !== 8'h42 || wq[1].cyc - wq[0].cyc != 1) begin
        err_cnt++;
        $display("FAIL b2b_writes got (%0d,%h,col%0d) (%0d,%h) gap=%0d required (0,41,col1) (1,42) gap=1",
                 wq[0].a, wq[0].d, wq[0].col, wq[1].a, wq[1].d, wq[1].cyc - wq[0].cyc);
      end
    end
    vec_cnt++;
    if (cur_col !== 7'd2 || cur_row !== 5'd0) begin
      err_cnt++;
      $display("FAIL b2b_cursor col=%0d row=%0d required 2 0", cur_col, cur_row);
    end
  endtask

  task automatic test_backspace();
    wq.delete();
    send(8'h08);
    settle();
    vec_cnt++;
    if (wq.size() != 1 || wq[0].a !== 12'd1 || wq[0].d !== 8'h20 || cur_col !== 7'd1) begin
      err_cnt++;
      $display("FAIL bs_write writes=%0d col=%0d required 1 write (1,20) col 1", wq.size(), cur_col);
    end
    wq.delete();
    send(8'h0D);
    send(8'h08);
    send(8'h01);
    send(8'h7F);
    settle();
    vec_cnt++;
    if (wq.size() != 0 || cur_col !== 7'd0 || cur_row !== 5'd0) begin
      err_cnt++;
      $display("FAIL bs_col0_noop writes=%0d col=%0d row=%0d required 0 0 0", wq.size(), cur_col, cur_row);
    end
  endtask

  task automatic test_newline();
    wq.delete();
    send(8'h0A);
    send(8'h43);
    settle();
    vec_cnt++;
    if (wq.size() != 1 || wq[0].a !== 12'd70 || wq[0].d !== 8'h43) begin
      err_cnt++;
      $display("FAIL lf_write writes=%0d required 1 write (70,43)", wq.size());
    end
    vec_cnt++;
    if (cur_col !== 7'd1 || cur_row !== 5'd1) begin
      err_cnt++;
      $display("FAIL lf_cursor col=%0d row=%0d required 1 1", cur_col, cur_row);
    end
  endtask

  task automatic test_line_wrap();
    int bad;
    wq.delete();
    for (int i = 0; i < 71; i++) send(8'(65 + i % 26));
    settle();
    bad = 0;
    foreach (wq[i]) if (wq[i].a !== 12'(i) || wq[i].d !== 8'(65 + i % 26)) bad++;
    vec_cnt++;
    if (wq.size() != 71 || bad != 0) begin
      err_cnt++;
      $display("FAIL wrap_writes count=%0d bad=%0d required 71 0", wq.size(), bad);
    end else begin
      vec_cnt++;
      if (wq[69].col !== 7'd0 || wq[69].row !== 5'd1 || wq[70].a !== 12'd70) begin
        err_cnt++;
        $display("FAIL wrap_last_col cursor=(%0d,%0d) next_addr=%0d required (1,0) 70",
                 wq[69].row, wq[69].col, wq[70].a);
      end
    end
    vec_cnt++;
    if (cur_col !== 7'd1 || cur_row !== 5'd1) begin
      err_cnt++;
      $display("FAIL wrap_cursor col=%0d row=%0d required 1 1", cur_col, cur_row);
    end
  endtask

  // Newline on the last row, then a character; base is the first address blanked.
  task automatic last_row_lf(input int base, input int exp_top, input int exp_row, input int exp_z_addr);
    int low;
    int bad;
    logic busy_seen;
    wq.delete();
    send(8'h0A);
    low = 0;
    busy_seen = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    while (char_ready !== 1'b1 && low < 200) begin
      low++;
      if (busy !== 1'b1) busy_seen = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    vec_cnt++;
    if (low != 70 || busy_seen !== 1'b1) begin
      err_cnt++;
      $display("FAIL clear_ready_low cycles=%0d busy=%b required 70 1", low, busy_seen);
    end
    bad = 0;
    foreach (wq[i]) if (wq[i].a !== 12'(base + i) || wq[i].d !== 8'h20) bad++;
    vec_cnt++;
    if (wq.size() != 70 || bad != 0) begin
      err_cnt++;
      $display("FAIL clear_writes count=%0d bad=%0d base=%0d required 70 0", wq.size(), bad, base);
    end
    vec_cnt++;
    if (top_row !== 5'(exp_top) || cur_row !== 5'(exp_row) || cur_col !== 7'd0) begin
      err_cnt++;
      $display("FAIL last_row_cursor top=%0d row=%0d col=%0d required %0d %0d 0",
               top_row, cur_row, cur_col, exp_top, exp_row);
    end
    wq.delete();
    send(8'h5A);
    settle();
    vec_cnt++;
    if (wq.size() != 1 || wq[0].a !== 12'(exp_z_addr) || wq[0].d !== 8'h5A || cur_col !== 7'd1) begin
      err_cnt++;
      $display("FAIL after_clear_write writes=%0d col=%0d required 1 write (%0d,5a) col 1",
               wq.size(), cur_col, exp_z_addr);
    end
  endtask

  task automatic test_last_row();
    wq.delete();
    send(8'h0D);
    for (int i = 0; i < 28; i++) send(8'h0A);
    settle();
    vec_cnt++;
    if (wq.size() != 0 || cur_row !== 5'd29 || cur_col !== 7'd0 || char_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL to_row29 writes=%0d row=%0d col=%0d rdy=%b required 0 29 0 1",
               wq.size(), cur_row, cur_col, char_ready);
    end
`ifdef TERM_SCROLL_EN
    last_row_lf(0, 1, 29, 0);
    last_row_lf(70, 2, 29, 70);
`else
    last_row_lf(0, 0, 0, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backspace();
    test_newline();
    test_reset();
    test_line_wrap();
    test_last_row();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/term_writer.md
# term_writer

Text-console writer for the VGA character display. Accepts a stream of ASCII bytes over a valid/ready handshake, maintains the cursor, and writes character codes into the 70×30 character buffer that the display path scans and feeds to the font ROM. Handles newline, carriage return, backspace, line wrap and hardware scrolling via a top-row pointer, so no buffer copying is needed. Sits between the keyboard/CPU character source and the character-buffer write port.

## Interface
- COLS, 70, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, buffer address width; must hold COLS*ROWS-1
- BLANK, 8'h20, fill character
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- char_valid  in  1  source has a character
- char_data  in  8  ASCII code
- char_ready  out  1  writer accepts; transfer on valid&ready at posedge
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer address = phys_row*COLS + col
- wr_data  out  8  character to write
- top_row  out  5  physical buffer row shown on screen line 0
- cur_col  out  7  cursor column, 0..COLS-1
- cur_row  out  5  cursor screen row, 0..ROWS-1
- busy  out  1  high in INIT_CLEAR or CLEAR_LINE

## Operation
- States: INIT_CLEAR, IDLE, CLEAR_LINE.
- INIT_CLEAR: entered on reset; writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, ascending; then IDLE.
- IDLE: char_ready=1. On accept:
  - 0x20..0x7E: write at cursor. If cur_col<COLS-1, col+1; else perform newline.
  - 0x0A: newline.
  - 0x0D: cur_col=0, no write.
  - 0x08: if cur_col>0, cur_col-1 and write BLANK at new position; at col 0, no-op.
  - Any other code: consumed, no write, no cursor change.
- Newline: cur_col=0. If cur_row<ROWS-1, cur_row+1. Otherwise scroll, per Configuration.
- CLEAR_LINE: writes BLANK to COLS consecutive addresses of the target physical row, then returns to IDLE.
- Physical row = (top_row+cur_row) mod ROWS, held in a register. The row base address is maintained incrementally: +COLS, wrapping to 0 after row ROWS-1. No multiplier.

## Timing
- Reset values:
  - char_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - top_row=0, cur_col=0, cur_row=0, busy=1.
  - State INIT_CLEAR.
- All outputs are registered. A write for a character accepted at edge N appears on wr_* during cycle N+1.
- Sustained throughput is 1 char/cycle in IDLE.
- char_ready drops in the cycle after an accept that triggers CLEAR_LINE. It stays low for exactly COLS cycles.
- A printable character in the last column writes first; CLEAR_LINE starts in the following cycle.
- Cursor outputs update in the same cycle as the corresponding write.
- rst during any state aborts immediately and restarts INIT_CLEAR with reset values. A partially cleared row is re-cleared.
- INIT_CLEAR lasts COLS*ROWS cycles, i.e. 2100 at defaults.

## Configuration
- TERM_SCROLL_EN defined: newline on the last row scrolls.
  - top_row = (top_row+1) mod ROWS; cur_row stays ROWS-1.
  - CLEAR_LINE blanks the old top physical row, which becomes the new bottom line.
- Undefined: newline on the last row wraps.
  - cur_row=0; top_row is constant 0.
  - CLEAR_LINE blanks physical row 0.

## Structure
- Package term_pkg holds:
  - COLS, ROWS, ADDR_W, BLANK defaults.
  - Control codes LF=8'h0A, CR=8'h0D, BS=8'h08.
  - Printable range bounds.
  - State enum term_state_t.
- One sub-module, term_row_ptr: a modular row counter plus its incremental base-address register. It is instantiated once for the cursor physical row and once for top_row.

## Test plan
- Reset → 2100 writes of 0x20 at addresses 0..2099 in order; char_ready=1 on the next cycle; cursor (0,0).
- Send 'A','B' back-to-back → writes (0,0x41) then (1,0x42) on consecutive cycles; cur_col=2.
- Send 0x0A then 'C' → no write for LF; write (70,0x43); cur_row=1, cur_col=1.
- From col 2 send 0x08 → write (1,0x20), cur_col=1. Move to col 0 with 0x0D, send 0x08 → no write, cursor unchanged.
- Send 71 printable chars from (0,0) → 71st written at address 70; cursor (1,1).
- With TERM_SCROLL_EN, cursor at row 29, send 0x0A:
  - top_row=1; 70 writes of 0x20 at 0..69 with char_ready low for 70 cycles.
  - Then 'Z' writes (0,0x5A).
  - Without the macro, same stimulus: cur_row=0, top_row=0, row 0 cleared.
